// File: rtl/bcd_acc_pkg.sv
// bcd_acc_pkg: op indices, FSM states and a constant BCD helper shared by the accumulator files
package bcd_acc_pkg;
    localparam int OP_INC1 = 0;
    localparam int OP_INC2 = 1;
    localparam int OP_DBL  = 2;
    localparam int OP_TRI  = 3;
    localparam int OP_DEC  = 4;
    localparam int OP_CLR  = 5;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

    function automatic logic [63:0] to_bcd(input int unsigned value, input int digits);
        logic [63:0] r;
        int unsigned v;
        r = '0;
        v = value;
        for (int i = 0; i < 16; i++) begin
            if (i < digits) begin
                r[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: serial double-dabble, one add-3/shift step per cycle, done held until the cycle after the last shift
module bin2bcd_seq #(
    parameter int VAL_W      = 15,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    start,
    input  logic [VAL_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);
    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0]        sr;
    logic [CNT_W-1:0]        cnt;
    logic [4*NUM_DIGITS-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    assign done = busy && cnt == '0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busy <= 1'b0;
            cnt  <= '0;
            sr   <= '0;
            bcd  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(VAL_W);
            sr   <= bin;
            bcd  <= '0;
        end else if (done) begin
            busy <= 1'b0;
        end else if (busy) begin
            {bcd, sr} <= {adj, sr} << 1;
            cnt       <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/bcd_op_accumulator.sv
// bcd_op_accumulator: trigger-driven binary accumulator with lockout, overflow/underflow flags
// and a multi-cycle BCD conversion feeding the display digits.
module bcd_op_accumulator
    import bcd_acc_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int LOCKOUT    = 1024,
    parameter int INIT_VALUE = 1
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [5:0]              Trigger,
    output logic [4*NUM_DIGITS-1:0] Digits,
    output logic                    Overflow,
    output logic                    Underflow,
    output logic                    Busy,
    output logic                    Valid
);
    localparam int MAX   = 10**NUM_DIGITS - 1;
    localparam int VAL_W = $clog2(3 * 10**NUM_DIGITS);
    localparam int CNT_W = $clog2(LOCKOUT + 1);
    localparam logic [63:0] INIT_BCD = to_bcd(INIT_VALUE, NUM_DIGITS);

    if (LOCKOUT < VAL_W + 2) begin : g_lockout_chk
        $error("LOCKOUT must be at least VAL_W+2");
    end
    if (INIT_VALUE > MAX) begin : g_init_chk
        $error("INIT_VALUE must not exceed MAX");
    end

    logic [VAL_W-1:0]        value, res;
    logic                    armed, accept, op_go, conv_done;
    logic [CNT_W-1:0]        lock_cnt;
    logic [4*NUM_DIGITS-1:0] conv_bcd;
    state_t                  state, next_state;

    assign accept = armed && |Trigger;
    // malformed patterns and non-clear ops while overflowed still consume the lockout
    assign op_go  = accept && $onehot(Trigger) && (!Overflow || Trigger[OP_CLR]);

    always_comb begin
        res = Trigger[OP_INC1] ? value + VAL_W'(1) :
              Trigger[OP_INC2] ? value + VAL_W'(2) :
              Trigger[OP_DBL]  ? value << 1 :
              Trigger[OP_TRI]  ? value * VAL_W'(3) :
              Trigger[OP_DEC]  ? (value == '0 ? '0 : value - VAL_W'(1)) :
                                 VAL_W'(INIT_VALUE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            armed    <= 1'b1;
            lock_cnt <= '0;
        end else if (accept) begin
            armed    <= 1'b0;
            lock_cnt <= CNT_W'(LOCKOUT - 1);
        end else begin
            if (lock_cnt != '0)
                lock_cnt <= lock_cnt - 1'b1;
            if (lock_cnt == '0 && Trigger == '0)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            value     <= VAL_W'(INIT_VALUE);
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            Underflow <= op_go && Trigger[OP_DEC] && value == '0;
            if (op_go) begin
                value    <= res;
                Overflow <= !Trigger[OP_CLR] && res > VAL_W'(MAX);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = (state == S_IDLE && op_go)         ? S_CONVERT :
                     (state == S_CONVERT && conv_done)  ? S_DONE :
                     (state == S_DONE)                  ? S_IDLE : state;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            Digits <= INIT_BCD[4*NUM_DIGITS-1:0];
        else if (state == S_CONVERT && conv_done)
            Digits <= Overflow ? '1 : conv_bcd;
    end

    assign Valid = state == S_DONE;

    bin2bcd_seq #(.VAL_W(VAL_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .start   (op_go),
        .bin     (res),
        .busy    (Busy),
        .done    (conv_done),
        .bcd     (conv_bcd)
    );
endmodule

// File: tb/tb_bcd_op_accumulator.sv
// tb_bcd_op_accumulator: directed and random trigger sequences checked against an arithmetic model
module tb_bcd_op_accumulator;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [5:0]  Trigger = '0;
    logic [15:0] Digits;
    logic        Overflow, Underflow, Busy, Valid;

    int          checks = 0;
    int          errors = 0;
    int          mval;
    bit          movf;
    logic [15:0] mdig;

    always #5 Clk = ~Clk;

    bcd_op_accumulator #(.NUM_DIGITS(4), .LOCKOUT(20), .INIT_VALUE(1)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Trigger   (Trigger),
        .Digits    (Digits),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .Busy      (Busy),
        .Valid     (Valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dec4(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model(input logic [5:0] t, output bit conv, output bit uf);
        conv = 0;
        uf   = 0;
        if ($onehot(t) && (!movf || t[5])) begin
            conv = 1;
            if (t[0]) mval = mval + 1;
            else if (t[1]) mval = mval + 2;
            else if (t[2]) mval = mval * 2;
            else if (t[3]) mval = mval * 3;
            else if (t[4]) begin
                if (mval == 0) uf = 1;
                else mval = mval - 1;
            end else begin
                mval = 1;
                movf = 0;
            end
            if (mval > 9999) movf = 1;
            mdig = movf ? 16'hFFFF : dec4(mval);
        end
    endtask

    // press t for `hold` edges; optionally press t2 on edge k+again+1 (again_ok: that press should land)
    task automatic do_op(input string tag, input logic [5:0] t, input int hold,
                         input int again, input logic [5:0] t2, input bit again_ok);
        bit conv, uf, conv2, uf2;
        int vcount = 0, vlat = -1, ucount = 0;
        model(t, conv, uf);
        conv2 = 0;
        if (again_ok) model(t2, conv2, uf2);
        @(negedge Clk);
        Trigger = t;
        @(posedge Clk);
        @(negedge Clk);
        check($sformatf("%s busy", tag), 32'(Busy), 32'(conv));
        check($sformatf("%s underflow", tag), 32'(Underflow), 32'(uf));
        Trigger = hold > 1 ? t : 6'd0;
        for (int c = 1; c <= hold + again + 25; c++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Valid) begin
                vcount++;
                if (vlat < 0) vlat = c;
            end
            if (Underflow) ucount++;
            Trigger = (again > 0 && c == again) ? t2 : (c + 1 < hold) ? t : 6'd0;
        end
        check($sformatf("%s valid_count", tag), 32'(vcount), 32'(int'(conv) + int'(conv2)));
        if (conv) check($sformatf("%s latency", tag), 32'(vlat), 32'd16);
        check($sformatf("%s underflow_len", tag), 32'(ucount), 32'd0);
        check($sformatf("%s digits", tag), 32'(Digits), 32'(mdig));
        check($sformatf("%s overflow", tag), 32'(Overflow), 32'(movf));
        check($sformatf("%s idle", tag), 32'(Busy), 32'd0);
    endtask

    initial begin
        int vc;
        int idx;
        logic [5:0] t;
        mval = 1;
        movf = 0;
        mdig = 16'h0001;
        repeat (3) @(negedge Clk);
        check("rst digits", 32'(Digits), 32'h0001);
        check("rst flags", 32'({Overflow, Underflow, Busy, Valid}), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("post_rst digits", 32'(Digits), 32'h0001);
        check("post_rst flags", 32'({Overflow, Underflow, Busy, Valid}), 32'd0);

        do_op("inc1", 6'h01, 1, 0, 6'h00, 0);
        do_op("clr", 6'h20, 1, 0, 6'h00, 0);
        do_op("hold_x2", 6'h04, 100, 0, 6'h00, 0);
        do_op("x2", 6'h04, 1, 0, 6'h00, 0);
        do_op("inc2", 6'h02, 1, 0, 6'h00, 0);
        do_op("lock5", 6'h01, 1, 5, 6'h01, 0);
        do_op("lock_edge_ign", 6'h01, 1, 19, 6'h01, 0);
        do_op("lock_edge_acc", 6'h01, 1, 20, 6'h01, 1);
        do_op("invalid", 6'h03, 1, 10, 6'h01, 0);

        do_op("clr2", 6'h20, 1, 0, 6'h00, 0);
        for (int b = 11; b >= 0; b--) begin
            do_op("build_x2", 6'h04, 1, 0, 6'h00, 0);
            if (((5000 >> b) & 1) != 0) do_op("build_inc", 6'h01, 1, 0, 6'h00, 0);
        end
        check("value_5000", 32'(Digits), 32'h5000);
        do_op("ovf_x3", 6'h08, 1, 0, 6'h00, 0);
        check("ovf digits", 32'(Digits), 32'hFFFF);
        do_op("ovf_ignored", 6'h01, 1, 0, 6'h00, 0);
        do_op("ovf_clear", 6'h20, 1, 0, 6'h00, 0);
        do_op("dec_to0", 6'h10, 1, 0, 6'h00, 0);
        do_op("dec_uf", 6'h10, 1, 0, 6'h00, 0);
        check("uf digits", 32'(Digits), 32'h0000);

        @(negedge Clk);
        Trigger = 6'h02;
        @(negedge Clk);
        Trigger = 6'h00;
        repeat (5) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("midrst busy", 32'(Busy), 32'd0);
        check("midrst digits", 32'(Digits), 32'h0001);
        check("midrst valid", 32'(Valid), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        mval = 1;
        movf = 0;
        mdig = 16'h0001;
        vc = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge Clk);
            if (Valid) vc++;
        end
        check("midrst no_valid", 32'(vc), 32'd0);
        check("midrst digits_hold", 32'(Digits), 32'h0001);

        for (int i = 0; i < 40; i++) begin
            idx = $urandom_range(0, 7);
            t = idx < 6 ? 6'(1 << idx) : 6'($urandom_range(1, 63));
            do_op($sformatf("rnd%0d", i), t, $urandom_range(1, 3), 0, 6'h00, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
